ov7670_pixel_capture: RTL and testbench

OV7670_PIXEL_CAPTURE -- requirements
Module: ov7670_pixel_capture

---
 rtl/ov7670_pkg.sv | 7 +
 rtl/pixel_fifo.sv | 42 ++++
 rtl/ov7670_pixel_capture.sv | 134 +++++++++++++
 tb/tb_ov7670_pixel_capture.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared types and defaults for the OV7670 pixel capture path.
package ov7670_pkg;
   typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, BYTE_HI, BYTE_LO} capture_state_t;
   typedef logic [15:0] pixel_t;
   localparam int DEF_FIFO_DEPTH  = 8;
   localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: single-clock show-ahead pixel buffer with synchronous flush.
module pixel_fifo
   import ov7670_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic   clk,
   input  logic   buttonReset,
   input  logic   flush,
   input  logic   push,
   input  pixel_t push_data,
   input  logic   pop,
   output pixel_t head,
   output logic   full,
   output logic   empty
);
   localparam int AW = $clog2(DEPTH);
   pixel_t mem_q [DEPTH];
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic do_pop, do_push;
   always_comb begin
      empty   = wr_q == rd_q;
      full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_d    = flush ? '0 : wr_q + (AW+1)'(do_push);
      rd_d    = flush ? '0 : rd_q + (AW+1)'(do_pop);
      head    = empty ? '0 : mem_q[rd_q[AW-1:0]];
   end
   always_ff @(posedge clk or posedge buttonReset) begin
      if (buttonReset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture: OV7670 byte stream to buffered RGB565 pixels.
// Line/pixel statistics are built only with OV7670_CAPTURE_STATS_EN defined.
module ov7670_pixel_capture
   import ov7670_pkg::*;
#(
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic        clk,
   input  logic        buttonReset,
   input  logic        pclk,
   input  logic        href,
   input  logic        vsync,
   input  logic [7:0]  cam_data,
   input  logic        pix_ready,
   output logic        pix_valid,
   output logic [15:0] pix_data,
   output logic        frame_start,
   output logic        overflow,
   output logic [8:0]  line_count,
   output logic [9:0]  last_line_pixels
);
   logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
   logic pclk_s, href_s, vsync_s;
   logic [7:0] data_s;
   logic pclk_p_q, href_p_q, vsync_p_q;
   logic pclk_rise, href_fall, vsync_rise, vsync_fall;
   capture_state_t state_q, state_d;
   logic [7:0] hi_q, hi_d;
   logic push_q, push_d;
   pixel_t push_data_q, push_data_d;
   logic frame_start_q, frame_start_d, overflow_q, overflow_d;
   logic full, empty;
   assign {pclk_s, href_s, vsync_s, data_s} = sync_q[SYNC_STAGES-1];
   assign pclk_rise  = pclk_s & ~pclk_p_q;
   assign href_fall  = ~href_s & href_p_q;
   assign vsync_rise = vsync_s & ~vsync_p_q;
   assign vsync_fall = ~vsync_s & vsync_p_q;
   assign pix_valid   = ~empty;
   assign frame_start = frame_start_q;
   assign overflow    = overflow_q;
   always_comb begin
      sync_d[0] = {pclk, href, vsync, cam_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      state_d     = state_q;
      hi_d        = hi_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      if (vsync_rise) state_d = WAIT_FRAME;
      else case (state_q)
         WAIT_FRAME: state_d = vsync_fall ? WAIT_LINE : WAIT_FRAME;
         WAIT_LINE:  state_d = (href_s && !vsync_s) ? BYTE_HI : WAIT_LINE;
         BYTE_HI:
            if (href_fall) state_d = WAIT_LINE;
            else if (pclk_rise && href_s) begin
               hi_d    = data_s;
               state_d = BYTE_LO;
            end
         default:
            if (href_fall) state_d = WAIT_LINE;
            else if (pclk_rise && href_s) begin
               push_d      = 1'b1;
               push_data_d = {hi_q, data_s};
               state_d     = BYTE_HI;
            end
      endcase
      frame_start_d = vsync_rise;
      // a push that finds the buffer full is lost unless a pop frees a slot on the same edge
      overflow_d    = vsync_rise ? 1'b0 : overflow_q | (push_q & full & ~(pix_valid & pix_ready));
   end
   always_ff @(posedge clk or posedge buttonReset) begin
      if (buttonReset) begin
         sync_q        <= '0;
         pclk_p_q      <= 1'b0;
         href_p_q      <= 1'b0;
         vsync_p_q     <= 1'b0;
         state_q       <= WAIT_FRAME;
         hi_q          <= '0;
         push_q        <= 1'b0;
         push_data_q   <= '0;
         frame_start_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         sync_q        <= sync_d;
         pclk_p_q      <= pclk_s;
         href_p_q      <= href_s;
         vsync_p_q     <= vsync_s;
         state_q       <= state_d;
         hi_q          <= hi_d;
         push_q        <= push_d;
         push_data_q   <= push_data_d;
         frame_start_q <= frame_start_d;
         overflow_q    <= overflow_d;
      end
   end
   pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .buttonReset(buttonReset),
      .flush(vsync_rise),
      .push(push_q),
      .push_data(push_data_q),
      .pop(pix_ready),
      .head(pix_data),
      .full(full),
      .empty(empty)
   );
`ifdef OV7670_CAPTURE_STATS_EN
   logic line_end;
   logic [8:0] line_q, line_d;
   logic [9:0] cnt_q, cnt_d, last_q, last_d;
   assign line_end = href_fall && !vsync_rise && (state_q == BYTE_HI || state_q == BYTE_LO);
   always_comb begin
      line_d = vsync_rise ? '0 : (line_end && line_q != 9'd511) ? line_q + 9'd1 : line_q;
      cnt_d  = (vsync_rise || line_end) ? '0 : (push_d && cnt_q != 10'd1023) ? cnt_q + 10'd1 : cnt_q;
      last_d = line_end ? cnt_q : last_q;
   end
   always_ff @(posedge clk or posedge buttonReset) begin
      if (buttonReset) begin
         line_q <= '0;
         cnt_q  <= '0;
         last_q <= '0;
      end else begin
         line_q <= line_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end
   assign line_count       = line_q;
   assign last_line_pixels = last_q;
`else
   assign line_count       = '0;
   assign last_line_pixels = '0;
`endif
endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// tb_ov7670_pixel_capture: randomized camera stimulus with a pixel scoreboard.
module tb_ov7670_pixel_capture;
   localparam int SYNC = 2;
   localparam int DEPTH = 8;
`ifdef OV7670_CAPTURE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic clk, buttonReset, pclk, href, vsync, pix_ready;
   logic [7:0] cam_data;
   logic pix_valid, frame_start, overflow;
   logic [15:0] pix_data;
   logic [8:0] line_count;
   logic [9:0] last_line_pixels;
   int checks = 0, errors = 0, fs_cnt = 0, accept_left = 1000000, lines_m = 0, last_m = 0;
   bit rand_ready = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;
   logic [7:0] lb [64];
   ov7670_pixel_capture #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .buttonReset(buttonReset), .pclk(pclk), .href(href), .vsync(vsync),
      .cam_data(cam_data), .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_data(pix_data),
      .frame_start(frame_start), .overflow(overflow), .line_count(line_count),
      .last_line_pixels(last_line_pixels)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (frame_start) fs_cnt++;
      if (!buttonReset && pix_valid && pix_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pixel_unexpected: got %h, none expected", pix_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (pix_data !== mon_exp) begin
               errors++;
               $display("FAIL pixel_data: got %h expected %h", pix_data, mon_exp);
            end
         end
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         if (rand_ready) pix_ready = ($urandom_range(0, 3) != 0);
      end
   endtask
   task automatic put_byte(input logic [7:0] b);
      pclk = 1'b0;
      cam_data = b;
      href = 1'b1;
      cyc(2);
      pclk = 1'b1;
   endtask
   task automatic end_line(input int np, input bit counted);
      pclk = 1'b0;
      href = 1'b0;
      cam_data = 8'($urandom);
      cyc(8);
      if (counted) begin
         lines_m = (lines_m < 511) ? lines_m + 1 : 511;
         last_m = np;
      end
      chk("line_count", line_count, STATS ? lines_m : 0);
      chk("last_line_pixels", last_line_pixels, STATS ? last_m : 0);
   endtask
   task automatic send_line(input int n);
      for (int i = 0; i < n; i++) begin
         put_byte(lb[i]);
         if (i % 2 == 1 && accept_left > 0) begin
            exp_q.push_back({lb[i-1], lb[i]});
            accept_left--;
         end
         cyc(2);
      end
      end_line(n / 2, 1'b1);
   endtask
   task automatic wait_fs();
      bit found = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (frame_start) begin
            found = 1;
            break;
         end
      end
      chk("frame_start_seen", found, 1);
   endtask
   task automatic start_frame();
      int b;
      b = fs_cnt;
      vsync = 1'b1;
      exp_q.delete();
      wait_fs();
      cyc(6);
      chk("frame_start_once", fs_cnt - b, 1);
      vsync = 1'b0;
      lines_m = 0;
      cyc(8);
   endtask
   task automatic drain();
      bit save;
      save = rand_ready;
      rand_ready = 0;
      pix_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (exp_q.size() == 0 && !pix_valid) break;
         cyc(1);
      end
      chk("drain_done", {exp_q.size() != 0, pix_valid}, 0);
      rand_ready = save;
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, pix_valid, 0);
      chk({tag, "_data"}, pix_data, 0);
      chk({tag, "_fs"}, frame_start, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_lc"}, line_count, 0);
      chk({tag, "_llp"}, last_line_pixels, 0);
   endtask
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
      $fatal(1, "timeout");
   end
   initial begin
      int lat;
      buttonReset = 1'b1;
      {pclk, href, vsync, pix_ready} = '0;
      cam_data = '0;
      repeat (3) @(posedge clk);
      #2;
      chk_zero("reset");
      buttonReset = 1'b0;
      cyc(4);
      chk("idle_valid", pix_valid, 0);
      // two pixels A1B2, C3D4 with consumer always ready
      start_frame();
      pix_ready = 1'b1;
      lb[0] = 8'hA1; lb[1] = 8'hB2; lb[2] = 8'hC3; lb[3] = 8'hD4;
      send_line(4);
      drain();
      // latency from second-byte pclk edge to pix_valid on an empty buffer
      pix_ready = 1'b0;
      put_byte(8'h5A);
      cyc(2);
      put_byte(8'hC3);
      exp_q.push_back(16'h5AC3);
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (pix_valid && lat == 0) lat = k;
      end
      chk("capture_latency", lat, SYNC + 2);
      end_line(1, 1'b1);
      drain();
      // randomized frames, random byte counts and a randomly stalling consumer
      for (int f = 0; f < 3; f++) begin
         drain();
         rand_ready = 1;
         start_frame();
         for (int l = 0; l < 4; l++) begin
            int n;
            n = $urandom_range(2, 24);
            for (int i = 0; i < n; i++) lb[i] = 8'($urandom);
            send_line(n);
         end
         drain();
         rand_ready = 0;
         chk("random_no_overflow", overflow, 0);
      end
      // odd byte count: trailing half pixel dropped, next line starts clean
      start_frame();
      pix_ready = 1'b1;
      lb[0] = 8'hE1; lb[1] = 8'hF2; lb[2] = 8'h07;
      send_line(3);
      for (int i = 0; i < 4; i++) lb[i] = 8'($urandom);
      send_line(4);
      drain();
      // full buffer with push and pop on the same edge
      pix_ready = 1'b0;
      for (int p = 0; p < DEPTH; p++) begin
         lb[0] = 8'($urandom); lb[1] = 8'($urandom);
         put_byte(lb[0]);
         cyc(2);
         put_byte(lb[1]);
         exp_q.push_back({lb[0], lb[1]});
         cyc(2);
      end
      cyc(4);
      chk("full_valid", pix_valid, 1);
      lb[0] = 8'h9C; lb[1] = 8'h3E;
      put_byte(lb[0]);
      cyc(2);
      put_byte(lb[1]);
      exp_q.push_back({lb[0], lb[1]});
      cyc(3);
      pix_ready = 1'b1;
      cyc(1);
      pix_ready = 1'b0;
      end_line(DEPTH + 1, 1'b1);
      chk("push_pop_full_ovf", overflow, 0);
      chk("push_pop_full_count", exp_q.size(), DEPTH);
      drain();
      // stalled consumer: ten pixels into an eight-deep buffer
      pix_ready = 1'b0;
      accept_left = DEPTH;
      for (int i = 0; i < 20; i++) lb[i] = 8'($urandom);
      send_line(20);
      chk("overflow_set", overflow, 1);
      chk("overflow_valid", pix_valid, 1);
      drain();
      accept_left = 1000000;
      chk("overflow_sticky", overflow, 1);
      // vsync rise with three pixels buffered flushes everything
      pix_ready = 1'b0;
      for (int i = 0; i < 6; i++) lb[i] = 8'($urandom);
      send_line(6);
      chk("flush_pre_valid", pix_valid, 1);
      begin
         int b;
         b = fs_cnt;
         vsync = 1'b1;
         exp_q.delete();
         wait_fs();
         @(negedge clk);
         chk("flush_valid", pix_valid, 0);
         chk("flush_ovf_clear", overflow, 0);
         chk("flush_lc_clear", line_count, 0);
         cyc(6);
         chk("flush_fs_once", fs_cnt - b, 1);
         vsync = 1'b0;
         lines_m = 0;
         pix_ready = 1'b1;
         cyc(8);
         chk("flush_post_valid", pix_valid, 0);
      end
      // reset in the middle of a line
      start_frame();
      pix_ready = 1'b1;
      put_byte(8'h11);
      cyc(2);
      put_byte(8'h22);
      exp_q.push_back(16'h1122);
      cyc(2);
      put_byte(8'h33);
      cyc(1);
      buttonReset = 1'b1;
      #1;
      chk_zero("midline_reset");
      exp_q.delete();
      lines_m = 0;
      last_m = 0;
      cyc(2);
      buttonReset = 1'b0;
      accept_left = 0;
      put_byte(8'h44); cyc(2);
      put_byte(8'h55); cyc(2);
      put_byte(8'h66); cyc(2);
      put_byte(8'h77); cyc(2);
      end_line(2, 1'b0);
      chk("post_reset_no_pixels", pix_valid, 0);
      accept_left = 1000000;
      start_frame();
      for (int i = 0; i < 4; i++) lb[i] = 8'($urandom);
      send_line(4);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
